timer_intc: RTL and testbench
=============================

# timer_intc

Memory-mapped timer and interrupt controller that responds to the CPU data-memory bus and drives the CPU `rupt` input. It sits in `sopc` beside `dm`. It decodes a 32-byte window of the data address space and returns read data on its own output, which `sopc` muxes onto `dm_out` when `hit` is high. It merges one down-counting timer and five external request lines into a pending/mask register pair.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_1000 — byte address of register window; must be 32-byte aligned.
- `N_EXT`, default 5 — external interrupt lines. Timer uses pending bit `N_EXT`, so there are 6 pending bits total.

Ports:
- `clk` in 1 — single clock. All flops on rising edge.
- `rst` in 1 — reset, asynchronous and active-high.
- `dm_en` in 1 — write strobe from CPU: 1 = write this cycle, 0 = read/idle.
- `dm_byte` in 4 — byte enables for writes; bit i covers data[8i+7:8i].
- `dm_addr` in 32 — byte address.
- `dm_in` in 32 — write data.
- `dm_out` out 32 — read data; combinational from address and registers; 0 when `hit`=0.
- `hit` out 1 — `dm_addr[31:5]==BASE_ADDR[31:5]`, combinational.
- `irq_in` in N_EXT — external requests; synchronous to `clk`; rising-edge sensitive.
- `rupt` out 1 — `|(pending & mask)`, driven directly from flops, no combinational input path.

## Operation
Register map, word offset = `dm_addr[4:2]`. Unlisted offsets read 0 and ignore writes.
- 0 CTRL: bit0 EN, bit1 AUTO (auto-reload). Other bits read 0.
- 1 PRESET[31:0]: reload value.
- 2 COUNT[31:0]: read gives the live count; a write loads the count.
- 3 PENDING[5:0]: write-1-to-clear.
- 4 MASK[5:0]: 1 = enabled.
- 5 IRQ_RAW[4:0]: read-only, current `irq_in` level.

Write rules:
- A write takes effect only when `hit & dm_en`.
- Each byte lane is updated only where `dm_byte` is set.
- PENDING clears are applied per lane: a bit clears only if its lane is enabled and the written bit is 1.

Timer state machine, states IDLE and RUN:
- IDLE → RUN when EN=1.
- RUN → IDLE when EN is written 0 (takes effect the next cycle), or on expiry with AUTO=0.
- In RUN, each cycle:
  - If COUNT≠0: COUNT ← COUNT−1.
  - If COUNT==0 (expiry): set pending[5]. If AUTO=1, COUNT ← PRESET. If AUTO=0, clear EN and go to IDLE with COUNT held at 0.
- Period with AUTO=1 is PRESET+1 cycles. PRESET=0 with AUTO=1 gives expiry every cycle.
- Setting EN does not load COUNT; software writes COUNT first.

External requests:
- `irq_q` register holds the previous `irq_in`.
- A rising edge (`irq_in & ~irq_q`) sets pending[i].
- Level is ignored after the edge.

Simultaneous events:
- Set and write-1-clear of the same pending bit in one cycle: set wins, and the bit stays 1.
- A software COUNT write in the same cycle as a decrement or reload: the write wins.
- A software COUNT write in the same cycle as expiry: the pending set still occurs; COUNT takes the written value.
- Writing EN=0 in the same cycle as expiry: the pending set still occurs.
- Counter arithmetic is 32-bit unsigned; no wrap below 0 ever happens.

## Timing
Reset values:
- CTRL=0, PRESET=0, COUNT=0, PENDING=0, MASK=0, `irq_q`=0, state IDLE.
- Therefore `rupt`=0.
- Combinational outputs (`dm_out`, `hit`) follow inputs.
- An `irq_in` line already high at reset release is seen as an edge on the first clock.

Latency and timing rules:
- Register writes are visible on read the cycle after the write edge.
- Event to `pending` to `rupt`: expiry or `irq_in` rising is sampled at edge N; `pending` and `rupt` are high after edge N.
- A write-1-to-clear at edge N drops `rupt` after edge N, unless another unmasked bit is pending.
- A MASK change affects `rupt` after the write edge.
- Reads have zero wait states: data is valid in the same cycle as the address. This matches `dm` read behaviour in `sopc`.
- An async `rst` assertion mid-count forces all reset values immediately; no event is generated.

## Structure
Shared package `timer_intc_pkg`:
- Register offset constants (`REG_CTRL`..`REG_IRQ_RAW`).
- CTRL bit indices.
- `TIMER_IRQ_BIT` = 5.
- State enum {IDLE, RUN}.

One natural sub-module is `down_timer`:
- Inputs: EN/AUTO/PRESET, count-write port.
- Outputs: COUNT, `expire` pulse, `en_clr`.
- Register file, edge detect, pending/mask and bus decode stay in `timer_intc`.

`sopc` integration:
- `dm_out` mux = `hit ? timer_intc.dm_out : dm.dm_out`.
- `dm` write strobe gated by `~hit`.

## Test plan
- **Reset:** assert `rst` mid-run with COUNT=7 → all registers read 0, `rupt`=0, no pending set after release.
- **One-shot timer:** write COUNT=3, MASK=6'h20, CTRL=1 → pending[5]=1 and `rupt`=1 after the 4th RUN edge; CTRL reads 0; COUNT holds 0; write PENDING=6'h20 → `rupt`=0 next cycle.
- **Auto-reload:** PRESET=2, COUNT=2, CTRL=3 → expiry every 3 cycles, 4 times observed.
- **Set-wins race:** clear pending[5] in the same cycle as expiry → pending[5] stays 1.
- **External edge:** `irq_in[2]` held high 10 cycles with MASK=6'h04 → pending[2] set once; clear while still high → stays clear; low then high → set again; MASK=0 → `rupt`=0 despite pending.
- **Byte-lane write:** write PRESET=32'hAABBCCDD with `dm_byte`=4'b0101 over 0 → reads 32'h00BB00DD. Read offset 6 → 0. Address outside window → `hit`=0, `dm_out`=0.

Source files
------------

// File: rtl/timer_intc_pkg.sv
// ============================================================================
// Module  : timer_intc_pkg
// Brief   : Shared register map, CTRL bit positions, timer state encoding and
//           byte-lane write helpers for the timer/interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_intc_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_PRESET  = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_PENDING = 3'd3;
    localparam logic [2:0] REG_MASK    = 3'd4;
    localparam logic [2:0] REG_IRQ_RAW = 3'd5;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int TIMER_IRQ_BIT = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = lane_mask(be);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_intc_if.sv
// ============================================================================
// Module  : timer_intc_if
// Brief   : CPU data-memory bus bundle seen by the timer/interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_intc_if;
    logic        dm_en;
    logic [3:0]  dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_in;
    logic [31:0] dm_out;
    logic        hit;

    modport master (
        output dm_en, dm_byte, dm_addr, dm_in,
        input  dm_out, hit
    );

    modport slave (
        input  dm_en, dm_byte, dm_addr, dm_in,
        output dm_out, hit
    );
endinterface

`default_nettype wire

// File: rtl/timer_intc_down_timer.sv
// ============================================================================
// Module  : timer_intc_down_timer
// Brief   : 32-bit down counter with one-shot / auto-reload expiry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_intc_down_timer
    import timer_intc_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en_i,
    input  wire logic        auto_i,
    input  wire logic [31:0] preset_i,
    input  wire logic        cnt_we_i,
    input  wire logic [31:0] cnt_wdata_i,
    output logic [31:0]      count_o,
    output logic             expire_o,
    output logic             en_clr_o
);

    timer_state_e state_q, state_d;
    logic [31:0]  count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        expire_o = 1'b0;
        en_clr_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    expire_o = 1'b1;
                    if (auto_i) begin
                        count_d = preset_i;
                    end else begin
                        en_clr_o = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Software load overrides any decrement or reload in the same cycle.
        if (cnt_we_i) count_d = cnt_wdata_i;
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/timer_intc.sv
// ============================================================================
// Module  : timer_intc
// Brief   : Memory-mapped timer plus edge-triggered interrupt controller
//           driving the CPU rupt input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_intc
    import timer_intc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          N_EXT     = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    timer_intc_if.slave           bus,
    input  wire logic [N_EXT-1:0] irq_in,
    output logic                  rupt
);

    localparam int NP = N_EXT + 1;

    logic [1:0]       ctrl_q, ctrl_d;
    logic [31:0]      preset_q, preset_d;
    logic [NP-1:0]    pending_q, pending_d;
    logic [NP-1:0]    mask_q, mask_d;
    logic [N_EXT-1:0] irq_q;

    logic        hit;
    logic        we;
    logic [2:0]  off;
    logic [31:0] lanes;
    logic [31:0] count;
    logic [31:0] cnt_wdata;
    logic        cnt_we;
    logic        expire;
    logic        en_clr;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    assign hit     = (bus.dm_addr[31:5] == BASE_ADDR[31:5]);
    assign off     = bus.dm_addr[4:2];
    assign we      = hit & bus.dm_en;
    assign lanes   = lane_mask(bus.dm_byte);
    assign bus.hit = hit;

    assign unused_addr_bits = ^bus.dm_addr[1:0];

    assign cnt_we    = we && (off == REG_COUNT) && (|bus.dm_byte);
    assign cnt_wdata = byte_merge(count, bus.dm_in, bus.dm_byte);

    timer_intc_down_timer u_down_timer (
        .clk         (clk),
        .rst         (rst),
        .en_i        (ctrl_q[CTRL_EN_BIT]),
        .auto_i      (ctrl_q[CTRL_AUTO_BIT]),
        .preset_i    (preset_q),
        .cnt_we_i    (cnt_we),
        .cnt_wdata_i (cnt_wdata),
        .count_o     (count),
        .expire_o    (expire),
        .en_clr_o    (en_clr)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        pending_d = pending_q;
        mask_d    = mask_q;

        if (en_clr) ctrl_d[CTRL_EN_BIT] = 1'b0;
        if (we && (off == REG_CTRL) && bus.dm_byte[0]) ctrl_d = bus.dm_in[1:0];

        if (we && (off == REG_PRESET))
            preset_d = byte_merge(preset_q, bus.dm_in, bus.dm_byte);

        if (we && (off == REG_MASK))
            mask_d = (mask_q & ~lanes[NP-1:0]) | (bus.dm_in[NP-1:0] & lanes[NP-1:0]);

        if (we && (off == REG_PENDING))
            pending_d = pending_q & ~(bus.dm_in[NP-1:0] & lanes[NP-1:0]);
        // Applied after the clear so a same-cycle event always survives.
        pending_d = pending_d | {expire, irq_in & ~irq_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_in;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            REG_CTRL:    rdata = {30'd0, ctrl_q};
            REG_PRESET:  rdata = preset_q;
            REG_COUNT:   rdata = count;
            REG_PENDING: rdata = 32'(pending_q);
            REG_MASK:    rdata = 32'(mask_q);
            REG_IRQ_RAW: rdata = 32'(irq_in);
            default:     rdata = '0;
        endcase
    end

    assign bus.dm_out = hit ? rdata : 32'd0;
    assign rupt       = |(pending_q & mask_q);

endmodule

`default_nettype wire

// File: tb/tb_timer_intc.sv
// ============================================================================
// Module  : tb_timer_intc
// Brief   : Directed self-checking bench for timer_intc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_intc;
    import timer_intc_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] irq_in;
    logic       rupt;
    int         n_tests = 0;
    int         n_fail  = 0;

    timer_intc_if bus ();

    timer_intc #(
        .BASE_ADDR (BASE),
        .N_EXT     (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .irq_in (irq_in),
        .rupt   (rupt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_addr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.dm_addr = addr;
        bus.dm_in   = data;
        bus.dm_byte = be;
        bus.dm_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.dm_en   = 1'b0;
        bus.dm_byte = 4'h0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        wr_addr(BASE + {27'd0, off, 2'b00}, data, 4'hF);
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [31:0] exp);
        bus.dm_addr = BASE + {27'd0, off, 2'b00};
        #1;
        check(tag, bus.dm_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        irq_in      = '0;
        bus.dm_en   = 1'b0;
        bus.dm_byte = 4'h0;
        bus.dm_addr = BASE;
        bus.dm_in   = '0;
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
        tick();

        // Reset state
        for (int r = 0; r < 6; r++) chk_reg("rst_reg", 3'(r), 32'd0);
        check("rst_rupt", rupt, 1'b0);
        check("rst_hit", bus.hit, 1'b1);

        // Byte-lane write, unmapped offset, out-of-window access
        wr_addr(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101);
        chk_reg("preset_lane", REG_PRESET, 32'h00BB_00DD);
        chk_reg("off6_zero", 3'd6, 32'd0);
        wr_addr(BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);
        chk_reg("preset_nohit_wr", REG_PRESET, 32'h00BB_00DD);
        bus.dm_addr = BASE + 32'h24;
        #1;
        check("outside_hit", bus.hit, 1'b0);
        check("outside_dout", bus.dm_out, 32'd0);

        // One-shot: COUNT=3, one IDLE->RUN edge then four RUN edges to expiry
        wr(REG_COUNT, 32'd3);
        wr(REG_MASK, 32'h20);
        wr(REG_CTRL, 32'd1);
        chk_reg("os_ctrl_en", REG_CTRL, 32'd1);
        tick();
        chk_reg("os_cnt_start", REG_COUNT, 32'd3);
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk_reg("os_cnt_dec", REG_COUNT, 32'(k));
        end
        check("os_rupt_early", rupt, 1'b0);
        tick();
        chk_reg("os_pend", REG_PENDING, 32'h20);
        check("os_rupt", rupt, 1'b1);
        chk_reg("os_ctrl_clr", REG_CTRL, 32'd0);
        chk_reg("os_cnt_zero", REG_COUNT, 32'd0);
        tick();
        chk_reg("os_cnt_hold", REG_COUNT, 32'd0);
        wr(REG_PENDING, 32'h20);
        check("os_rupt_clr", rupt, 1'b0);
        chk_reg("os_pend_clr", REG_PENDING, 32'd0);

        // Auto-reload: period PRESET+1 = 3 cycles
        wr(REG_PRESET, 32'd2);
        wr(REG_COUNT, 32'd2);
        wr(REG_CTRL, 32'd3);
        repeat (3) tick();
        chk_reg("ar_cnt0", REG_COUNT, 32'd0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk_reg("ar_pend", REG_PENDING, 32'h20);
            chk_reg("ar_reload", REG_COUNT, 32'd2);
            check("ar_rupt", rupt, 1'b1);
            wr(REG_PENDING, 32'h20);
            chk_reg("ar_pend_clr", REG_PENDING, 32'd0);
            chk_reg("ar_cnt1", REG_COUNT, 32'd1);
            tick();
            chk_reg("ar_cnt0b", REG_COUNT, 32'd0);
        end

        // Clear on the expiry edge: the set wins
        wr(REG_PENDING, 32'h20);
        chk_reg("race_pend", REG_PENDING, 32'h20);
        chk_reg("race_reload", REG_COUNT, 32'd2);
        wr(REG_CTRL, 32'd0);
        repeat (2) tick();
        chk_reg("stop_cnt", REG_COUNT, 32'd1);
        chk_reg("stop_ctrl", REG_CTRL, 32'd0);
        wr(REG_PENDING, 32'h20);
        chk_reg("stop_pend", REG_PENDING, 32'd0);

        // External edge detection on irq_in[2]
        wr(REG_MASK, 32'h04);
        irq_in = 5'b00100;
        tick();
        chk_reg("ext_set", REG_PENDING, 32'h04);
        check("ext_rupt", rupt, 1'b1);
        repeat (2) tick();
        chk_reg("ext_level", REG_PENDING, 32'h04);
        wr(REG_PENDING, 32'h04);
        chk_reg("ext_clr", REG_PENDING, 32'd0);
        check("ext_rupt_clr", rupt, 1'b0);
        repeat (5) tick();
        chk_reg("ext_stay_clr", REG_PENDING, 32'd0);
        chk_reg("ext_raw", REG_IRQ_RAW, 32'h04);
        irq_in = 5'b00000;
        tick();
        chk_reg("ext_low", REG_PENDING, 32'd0);
        irq_in = 5'b00100;
        tick();
        chk_reg("ext_reedge", REG_PENDING, 32'h04);
        wr(REG_MASK, 32'h00);
        check("ext_masked_rupt", rupt, 1'b0);
        chk_reg("ext_masked_pend", REG_PENDING, 32'h04);
        irq_in = 5'b00000;

        // Asynchronous reset mid-count
        wr(REG_MASK, 32'h3F);
        check("pre_rst_rupt", rupt, 1'b1);
        wr(REG_COUNT, 32'd7);
        wr(REG_CTRL, 32'd1);
        repeat (2) tick();
        chk_reg("pre_rst_cnt", REG_COUNT, 32'd6);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_rupt", rupt, 1'b0);
        for (int r = 0; r < 6; r++) chk_reg("mid_rst_reg", 3'(r), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk_reg("post_rst_pend", REG_PENDING, 32'd0);
        chk_reg("post_rst_cnt", REG_COUNT, 32'd0);
        chk_reg("post_rst_ctrl", REG_CTRL, 32'd0);
        check("post_rst_rupt", rupt, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
